// File: rtl/watchdog_top_if.sv
// ---------------------------------------------------------------------------
// watchdog_top_if
// Groups the register/data bus and the status outputs of the watchdog.
//   abus     [2:0]  register address (000 FRAME, 001 SVC, 011 LIMIT, 010 CTRL)
//   dbus     [15:0] data / unlock key bus, sampled every rising edge
//   adc_in   [19:0] unsigned supply-voltage sample
//   rstout          registered system reset request
//   wdfail          registered watchdog failure / recovery in progress
//   flstat   [2:0]  failure cause (000 none, 001 early, 010 timeout, 100 brownout)
//   brownout        registered brownout flag
// master: the side that drives the bus (system / testbench)
// slave : the watchdog itself
// ---------------------------------------------------------------------------
interface watchdog_top_if;
   logic [2:0]  abus;
   logic [15:0] dbus;
   logic [19:0] adc_in;
   logic        rstout;
   logic        wdfail;
   logic [2:0]  flstat;
   logic        brownout;

   modport master (
      output abus, dbus, adc_in,
      input  rstout, wdfail, flstat, brownout
   );

   modport slave (
      input  abus, dbus, adc_in,
      output rstout, wdfail, flstat, brownout
   );
endinterface

// File: rtl/watchdog_top.sv
// ---------------------------------------------------------------------------
// watchdog_top
// Windowed watchdog with key-protected configuration and brownout detection.
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : watchdog_top_if.slave (abus/dbus/adc_in in; rstout/wdfail/
//          flstat/brownout out, all outputs registered)
// Writes are only accepted during a short window opened by the key pair
// KEY1 followed by KEY2.  CTRL is a write-only command register: bit4 INIT
// starts/restarts the frame, bit3 KICK services the watchdog.
// ---------------------------------------------------------------------------
module watchdog_top #(
   parameter logic [15:0] KEY1      = 16'hAAAA,
   parameter logic [15:0] KEY2      = 16'h5555,
   parameter int unsigned WR_CYCLES = 4,
   parameter logic [19:0] BO_THRESH = 20'h80000
) (
   input logic           clk,
   input logic           rst,
   watchdog_top_if.slave bus
);

   localparam logic [15:0] WR_LOAD = 16'(WR_CYCLES);

   localparam logic [2:0] ADDR_FRAME = 3'b000;
   localparam logic [2:0] ADDR_SVC   = 3'b001;
   localparam logic [2:0] ADDR_CTRL  = 3'b010;
   localparam logic [2:0] ADDR_LIMIT = 3'b011;

   localparam logic [2:0] CAUSE_NONE    = 3'b000;
   localparam logic [2:0] CAUSE_EARLY   = 3'b001;
   localparam logic [2:0] CAUSE_TIMEOUT = 3'b010;
   localparam logic [2:0] CAUSE_BROWN   = 3'b100;

   typedef enum logic [1:0] {
      U_IDLE,
      U_ARMED,
      U_WINDOW
   } unlock_state_t;

   typedef enum logic [1:0] {
      WD_IDLE,
      WD_RUN,
      WD_RECOVER
   } wd_state_t;

   unlock_state_t unlock_state_q, unlock_state_d;
   logic [15:0]   win_cnt_q, win_cnt_d;

   logic [15:0] frame_q, frame_d;
   logic [15:0] svc_q, svc_d;
   logic [15:0] limit_q, limit_d;

   wd_state_t   wd_state_q, wd_state_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] down_cnt_q, down_cnt_d;

   logic        rstout_q, rstout_d;
   logic        wdfail_q, wdfail_d;
   logic [2:0]  flstat_q, flstat_d;
   logic        brownout_q, brownout_d;

   logic write_en;
   logic ctrl_wr;
   logic init_cmd;
   logic kick_cmd;
   logic bo_now;

   // Unlock sequencer: KEY1 (possibly repeated) arms, the next differing
   // value must be KEY2 to open the write window.  Values sampled while the
   // window is open are data, never keys, so KEY1 cannot close the window.
   always_comb begin
      unlock_state_d = unlock_state_q;
      win_cnt_d      = win_cnt_q;
      case (unlock_state_q)
         U_IDLE: begin
            if (bus.dbus == KEY1) begin
               unlock_state_d = U_ARMED;
            end
         end
         U_ARMED: begin
            if (bus.dbus == KEY1) begin
               unlock_state_d = U_ARMED;
            end else if (bus.dbus == KEY2 && WR_LOAD != 16'd0) begin
               unlock_state_d = U_WINDOW;
               win_cnt_d      = WR_LOAD;
            end else begin
               unlock_state_d = U_IDLE;
            end
         end
         U_WINDOW: begin
            // The edge consuming the last remaining slot closes the window.
            if (win_cnt_q <= 16'd1) begin
               unlock_state_d = U_IDLE;
               win_cnt_d      = 16'd0;
            end else begin
               win_cnt_d = win_cnt_q - 16'd1;
            end
         end
         default: begin
            unlock_state_d = U_IDLE;
            win_cnt_d      = 16'd0;
         end
      endcase
   end

   // Register writes and CTRL command decode.  INIT has priority over KICK
   // when both bits arrive in the same CTRL write.
   always_comb begin
      write_en = (unlock_state_q == U_WINDOW);
      ctrl_wr  = write_en && (bus.abus == ADDR_CTRL);
      init_cmd = ctrl_wr && bus.dbus[4];
      kick_cmd = ctrl_wr && bus.dbus[3] && !bus.dbus[4];
      bo_now   = (bus.adc_in < BO_THRESH);

      frame_d = frame_q;
      svc_d   = svc_q;
      limit_d = limit_q;
      if (write_en) begin
         case (bus.abus)
            ADDR_FRAME: frame_d = bus.dbus;
            ADDR_SVC:   svc_d   = bus.dbus;
            ADDR_LIMIT: limit_d = bus.dbus;
            default:    ;
         endcase
      end
   end

   // Watchdog sequencer.  Brownout is evaluated on the current ADC sample so
   // that BROWNOUT, RSTOUT and FLSTAT=100 all appear on the same edge, and it
   // takes precedence over anything the watchdog would otherwise do.
   always_comb begin
      wd_state_d  = wd_state_q;
      frame_cnt_d = frame_cnt_q;
      down_cnt_d  = down_cnt_q;
      rstout_d    = rstout_q;
      wdfail_d    = wdfail_q;
      flstat_d    = flstat_q;
      brownout_d  = bo_now;

      if (bo_now) begin
         wd_state_d  = WD_IDLE;
         frame_cnt_d = 16'd0;
         down_cnt_d  = 16'd0;
         rstout_d    = 1'b1;
         wdfail_d    = 1'b0;
         flstat_d    = CAUSE_BROWN;
      end else begin
         case (wd_state_q)
            WD_IDLE: begin
               rstout_d = 1'b0;
               wdfail_d = 1'b0;
               if (init_cmd) begin
                  wd_state_d  = WD_RUN;
                  frame_cnt_d = 16'd0;
                  flstat_d    = CAUSE_NONE;
               end
            end
            WD_RUN: begin
               rstout_d = 1'b0;
               wdfail_d = 1'b0;
               // An early kick is checked before the timeout so that an
               // SVC >= FRAME setting turns every kick into an early fail.
               if (init_cmd) begin
                  frame_cnt_d = 16'd0;
               end else if (kick_cmd && frame_cnt_q < svc_q) begin
                  wd_state_d  = WD_RECOVER;
                  frame_cnt_d = 16'd0;
                  down_cnt_d  = limit_q;
                  rstout_d    = 1'b1;
                  wdfail_d    = 1'b1;
                  flstat_d    = CAUSE_EARLY;
               end else if (frame_cnt_q >= frame_q) begin
                  wd_state_d  = WD_RECOVER;
                  frame_cnt_d = 16'd0;
                  down_cnt_d  = limit_q;
                  rstout_d    = 1'b1;
                  wdfail_d    = 1'b1;
                  flstat_d    = CAUSE_TIMEOUT;
               end else if (kick_cmd) begin
                  frame_cnt_d = 16'd0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end
            end
            WD_RECOVER: begin
               // The load edge counts as the first recovery cycle, so LIMIT
               // cycles of RSTOUT are produced; LIMIT=0 still gives one.
               rstout_d = 1'b1;
               wdfail_d = 1'b1;
               if (down_cnt_q <= 16'd1) begin
                  wd_state_d = WD_IDLE;
                  down_cnt_d = 16'd0;
                  rstout_d   = 1'b0;
                  wdfail_d   = 1'b0;
               end else begin
                  down_cnt_d = down_cnt_q - 16'd1;
               end
            end
            default: begin
               wd_state_d  = WD_IDLE;
               frame_cnt_d = 16'd0;
               down_cnt_d  = 16'd0;
               rstout_d    = 1'b0;
               wdfail_d    = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         unlock_state_q <= U_IDLE;
         win_cnt_q      <= 16'd0;
         frame_q        <= 16'h0010;
         svc_q          <= 16'h0004;
         limit_q        <= 16'h0004;
         wd_state_q     <= WD_IDLE;
         frame_cnt_q    <= 16'd0;
         down_cnt_q     <= 16'd0;
         rstout_q       <= 1'b0;
         wdfail_q       <= 1'b0;
         flstat_q       <= CAUSE_NONE;
         brownout_q     <= 1'b0;
      end else begin
         unlock_state_q <= unlock_state_d;
         win_cnt_q      <= win_cnt_d;
         frame_q        <= frame_d;
         svc_q          <= svc_d;
         limit_q        <= limit_d;
         wd_state_q     <= wd_state_d;
         frame_cnt_q    <= frame_cnt_d;
         down_cnt_q     <= down_cnt_d;
         rstout_q       <= rstout_d;
         wdfail_q       <= wdfail_d;
         flstat_q       <= flstat_d;
         brownout_q     <= brownout_d;
      end
   end

   assign bus.rstout   = rstout_q;
   assign bus.wdfail   = wdfail_q;
   assign bus.flstat   = flstat_q;
   assign bus.brownout = brownout_q;

endmodule

// File: tb/tb_watchdog_top.sv
// ---------------------------------------------------------------------------
// tb_watchdog_top
// Directed, table-driven bench for watchdog_top.  Each record holds one
// clock's inputs and the outputs expected just after that clock's rising
// edge, packed as {rstout, wdfail, flstat[2:0], brownout}.  Reset behaviour
// is exercised by hand-written sequences around the table.
// ---------------------------------------------------------------------------
module tb_watchdog_top;

   typedef struct {
      logic [2:0]  abus;
      logic [15:0] dbus;
      logic [19:0] adc;
      logic [5:0]  expv;
   } vec_t;

   localparam logic [19:0] ADC_OK   = 20'hFFFFF;
   localparam logic [19:0] ADC_LOW  = 20'h7FFFF;
   localparam logic [19:0] ADC_EDGE = 20'h80000;

   localparam logic [5:0] EXP_CLR        = 6'b0_0_000_0;
   localparam logic [5:0] EXP_EARLY      = 6'b1_1_001_0;
   localparam logic [5:0] EXP_EARLY_HELD = 6'b0_0_001_0;
   localparam logic [5:0] EXP_TMO        = 6'b1_1_010_0;
   localparam logic [5:0] EXP_TMO_HELD   = 6'b0_0_010_0;
   localparam logic [5:0] EXP_BO         = 6'b1_0_100_1;
   localparam logic [5:0] EXP_BO_HELD    = 6'b0_0_100_0;

   logic clk = 1'b0;
   logic rst;
   vec_t vecs[$];
   int   vec_count  = 0;
   int   miss_count = 0;

   watchdog_top_if bus ();

   watchdog_top dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Append one clock's worth of stimulus and expectation to the table.
   function automatic void push(input logic [2:0] a, input logic [15:0] d,
                                input logic [19:0] adc, input logic [5:0] e);
      vec_t v;
      v.abus = a;
      v.dbus = d;
      v.adc  = adc;
      v.expv = e;
      vecs.push_back(v);
   endfunction

   function automatic void push_n(input int n, input logic [2:0] a, input logic [15:0] d,
                                  input logic [19:0] adc, input logic [5:0] e);
      for (int k = 0; k < n; k++) begin
         push(a, d, adc, e);
      end
   endfunction

   // Drive inputs away from the rising edge, then let one edge pass.
   task automatic apply_stimulus(input logic r, input logic [2:0] a,
                                 input logic [15:0] d, input logic [19:0] adc);
      @(negedge clk);
      rst        = r;
      bus.abus   = a;
      bus.dbus   = d;
      bus.adc_in = adc;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [5:0] e);
      logic [5:0] act;
      act = {bus.rstout, bus.wdfail, bus.flstat, bus.brownout};
      vec_count++;
      if (act !== e) begin
         miss_count++;
         $display("[TB] FAIL %s: got {rstout,wdfail,flstat,bo}=%b, want %b", name, act, e);
      end
   endtask

   task automatic step(input string name, input logic r, input logic [2:0] a,
                       input logic [15:0] d, input logic [5:0] e);
      apply_stimulus(r, a, d, ADC_OK);
      check_output(name, e);
   endtask

   initial begin
      rst        = 1'b1;
      bus.abus   = 3'b000;
      bus.dbus   = 16'h0000;
      bus.adc_in = ADC_OK;

      // Configuration after noise and repeated KEY1: FRAME=10, SVC=3, LIMIT=4.
      push(3'b000, 16'h3636, ADC_OK, EXP_CLR);
      push(3'b000, 16'h1111, ADC_OK, EXP_CLR);
      push_n(3, 3'b000, 16'hAAAA, ADC_OK, EXP_CLR);
      push(3'b000, 16'h5555, ADC_OK, EXP_CLR);
      push(3'b000, 16'h000A, ADC_OK, EXP_CLR);
      push(3'b001, 16'h0003, ADC_OK, EXP_CLR);
      push(3'b011, 16'h0004, ADC_OK, EXP_CLR);
      push(3'b010, 16'h0000, ADC_OK, EXP_CLR);

      // INIT then immediate KICK: early fail, four recovery clocks.
      push(3'b000, 16'hAAAA, ADC_OK, EXP_CLR);
      push(3'b000, 16'h5555, ADC_OK, EXP_CLR);
      push(3'b010, 16'h0010, ADC_OK, EXP_CLR);
      push(3'b010, 16'h0008, ADC_OK, EXP_EARLY);
      push_n(2, 3'b100, 16'h0000, ADC_OK, EXP_EARLY);
      push(3'b000, 16'h0000, ADC_OK, EXP_EARLY);
      push_n(2, 3'b000, 16'h0000, ADC_OK, EXP_EARLY_HELD);

      // INIT with no kick: counter 0..9 quiet, timeout when it reaches 10.
      push(3'b000, 16'hAAAA, ADC_OK, EXP_EARLY_HELD);
      push(3'b000, 16'h5555, ADC_OK, EXP_EARLY_HELD);
      push(3'b010, 16'h0010, ADC_OK, EXP_CLR);
      push_n(3, 3'b100, 16'h0000, ADC_OK, EXP_CLR);
      push_n(7, 3'b000, 16'h0000, ADC_OK, EXP_CLR);
      push_n(4, 3'b000, 16'h0000, ADC_OK, EXP_TMO);
      push(3'b000, 16'h0000, ADC_OK, EXP_TMO_HELD);

      // Kick at counter 5 in three frames; an unlocked INIT is then ignored,
      // so the timeout arrives exactly when the unreset counter reaches 10.
      push(3'b000, 16'hAAAA, ADC_OK, EXP_TMO_HELD);
      push(3'b000, 16'h5555, ADC_OK, EXP_TMO_HELD);
      push(3'b010, 16'h0010, ADC_OK, EXP_CLR);
      push_n(3, 3'b100, 16'h0000, ADC_OK, EXP_CLR);
      for (int f = 0; f < 3; f++) begin
         push(3'b000, 16'hAAAA, ADC_OK, EXP_CLR);
         push(3'b000, 16'h5555, ADC_OK, EXP_CLR);
         push(3'b010, 16'h0008, ADC_OK, EXP_CLR);
         push_n(3, 3'b100, 16'h0000, ADC_OK, EXP_CLR);
      end
      push(3'b010, 16'h0010, ADC_OK, EXP_CLR);
      push_n(6, 3'b000, 16'h0000, ADC_OK, EXP_CLR);
      push_n(4, 3'b000, 16'h0000, ADC_OK, EXP_TMO);
      push(3'b000, 16'h0000, ADC_OK, EXP_TMO_HELD);

      // Broken key sequence: no window, INIT ignored, cause stays 010.
      push(3'b000, 16'hAAAA, ADC_OK, EXP_TMO_HELD);
      push(3'b000, 16'h1234, ADC_OK, EXP_TMO_HELD);
      push(3'b000, 16'h5555, ADC_OK, EXP_TMO_HELD);
      push(3'b010, 16'h0010, ADC_OK, EXP_TMO_HELD);
      push_n(12, 3'b000, 16'h0000, ADC_OK, EXP_TMO_HELD);

      // Brownout threshold boundary while idle.
      push(3'b000, 16'h0000, ADC_EDGE, EXP_TMO_HELD);
      push(3'b000, 16'h0000, ADC_LOW, EXP_BO);
      push(3'b000, 16'h0000, ADC_OK, EXP_BO_HELD);

      // Brownout during RUN forces IDLE: no timeout afterwards.
      push(3'b000, 16'hAAAA, ADC_OK, EXP_BO_HELD);
      push(3'b000, 16'h5555, ADC_OK, EXP_BO_HELD);
      push(3'b010, 16'h0010, ADC_OK, EXP_CLR);
      push_n(3, 3'b100, 16'h0000, ADC_OK, EXP_CLR);
      push_n(2, 3'b000, 16'h0000, ADC_OK, EXP_CLR);
      push_n(2, 3'b000, 16'h0000, ADC_LOW, EXP_BO);
      push_n(13, 3'b000, 16'h0000, ADC_OK, EXP_BO_HELD);

      // Brownout on the very edge the timeout would fire wins over it.
      push(3'b000, 16'hAAAA, ADC_OK, EXP_BO_HELD);
      push(3'b000, 16'h5555, ADC_OK, EXP_BO_HELD);
      push(3'b010, 16'h0010, ADC_OK, EXP_CLR);
      push_n(3, 3'b100, 16'h0000, ADC_OK, EXP_CLR);
      push_n(7, 3'b000, 16'h0000, ADC_OK, EXP_CLR);
      push(3'b000, 16'h0000, ADC_LOW, EXP_BO);
      push_n(3, 3'b000, 16'h0000, ADC_OK, EXP_BO_HELD);

      // LIMIT=0 and FRAME=0: timeout on first RUN clock, one-clock pulse.
      push(3'b000, 16'hAAAA, ADC_OK, EXP_BO_HELD);
      push(3'b000, 16'h5555, ADC_OK, EXP_BO_HELD);
      push(3'b011, 16'h0000, ADC_OK, EXP_BO_HELD);
      push(3'b000, 16'h0000, ADC_OK, EXP_BO_HELD);
      push(3'b010, 16'h0010, ADC_OK, EXP_CLR);
      push(3'b100, 16'h0000, ADC_OK, EXP_TMO);
      push_n(2, 3'b000, 16'h0000, ADC_OK, EXP_TMO_HELD);

      // Reset state.
      step("reset_0", 1'b1, 3'b000, 16'h0000, EXP_CLR);
      step("reset_1", 1'b1, 3'b000, 16'h0000, EXP_CLR);

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(1'b0, vecs[i].abus, vecs[i].dbus, vecs[i].adc);
         check_output($sformatf("vec%0d", i), vecs[i].expv);
      end

      // Reset in the middle of recovery (window still open) aborts it and
      // closes the window; the later writes of 0 to FRAME must not land.
      step("rst_defaults", 1'b1, 3'b000, 16'h0000, EXP_CLR);
      step("abort_key1", 1'b0, 3'b000, 16'hAAAA, EXP_CLR);
      step("abort_key2", 1'b0, 3'b000, 16'h5555, EXP_CLR);
      step("abort_init", 1'b0, 3'b010, 16'h0010, EXP_CLR);
      step("abort_kick", 1'b0, 3'b010, 16'h0008, EXP_EARLY);
      step("abort_rst", 1'b1, 3'b000, 16'h0000, EXP_CLR);
      for (int k = 0; k < 6; k++) begin
         step($sformatf("abort_quiet%0d", k), 1'b0, 3'b000, 16'h0000, EXP_CLR);
      end

      // Default FRAME=16 and LIMIT=4 after reset.
      step("dflt_key1", 1'b0, 3'b000, 16'hAAAA, EXP_CLR);
      step("dflt_key2", 1'b0, 3'b000, 16'h5555, EXP_CLR);
      step("dflt_init", 1'b0, 3'b010, 16'h0010, EXP_CLR);
      for (int k = 0; k < 3; k++) begin
         step($sformatf("dflt_win%0d", k), 1'b0, 3'b100, 16'h0000, EXP_CLR);
      end
      for (int k = 0; k < 13; k++) begin
         step($sformatf("dflt_run%0d", k), 1'b0, 3'b000, 16'h0000, EXP_CLR);
      end
      for (int k = 0; k < 4; k++) begin
         step($sformatf("dflt_tmo%0d", k), 1'b0, 3'b000, 16'h0000, EXP_TMO);
      end
      step("dflt_done", 1'b0, 3'b000, 16'h0000, EXP_TMO_HELD);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
